// File: rtl/r4u2_pingpong_ram.sv
// rtl/r4u2_pingpong_ram.sv - dual-bank ping-pong frame buffer between radix-4 FFT stages
//
// The writer fills the FREE bank at arbitrary addresses while the reader drains
// the FULL bank at arbitrary addresses. Banks swap on frame-end markers.
//
// Ports:
//   clk_sys  - system clock, rising edge
//   rst_sys  - synchronous active-high reset
//   wr_en    - write strobe, active low
//   wr_addr  - write address within the current write bank
//   wr_data  - write data
//   wr_last  - last write of a frame (only with wr_en=0)
//   wr_rdy   - current write bank is free
//   wr_ovf   - one-cycle pulse after a write was dropped on a full bank
//   rd_req   - read request, active high
//   rd_addr  - read address within the current read bank
//   rd_last  - last read of a frame (only with an accepted rd_req)
//   rd_rdy   - current read bank holds a complete frame
//   rd_data  - registered read data
//   rd_vld   - rd_data valid this cycle

`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 4
`endif

module r4u2_pingpong_ram #(
    parameter int DATA_W = `MAN_WIDTH + `MAN_WIDTH + `EXP_WIDTH,
    parameter int ADDR_W = 6
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_rdy,
    output logic              wr_ovf,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_last,
    output logic              rd_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        wr_bank;
    logic        wr_bank_d;
    logic        rd_bank;
    logic        rd_bank_d;

    // Both banks live in one array; the bank pointer is the address MSB.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    logic wr_acc;
    logic rd_acc;

    assign wr_rdy = (bank_q[wr_bank] == BANK_FREE);
    assign rd_rdy = (bank_q[rd_bank] == BANK_FULL);

    // Reset blocks the memory write so a reset cycle has no side effects.
    assign wr_acc = ~wr_en & wr_rdy & ~rst_sys;
    assign rd_acc = rd_req & rd_rdy;

    // Write bank is always FREE and read bank always FULL, so the two
    // updates below never touch the same bank and can both apply.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank;
        rd_bank_d = rd_bank;
        if (wr_acc && wr_last) begin
            bank_d[wr_bank] = BANK_FULL;
            wr_bank_d       = ~wr_bank;
        end
        if (rd_acc && rd_last) begin
            bank_d[rd_bank] = BANK_FREE;
            rd_bank_d       = ~rd_bank;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            bank_q[0] <= BANK_FREE;
            bank_q[1] <= BANK_FREE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_bank   <= wr_bank_d;
            rd_bank   <= rd_bank_d;
        end
    end

    // Storage is not reset; stale contents are unreachable until a new frame completes.
    always_ff @(posedge clk_sys) begin
        if (wr_acc) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
            wr_ovf  <= 1'b0;
        end else begin
            rd_vld <= rd_acc;
            wr_ovf <= ~wr_en & ~wr_rdy;
            if (rd_acc) begin
                rd_data <= mem[{rd_bank, rd_addr}];
            end
        end
    end

endmodule

// File: tb/tb_r4u2_pingpong_ram.sv
// tb/tb_r4u2_pingpong_ram.sv - scoreboard bench for r4u2_pingpong_ram
module tb_r4u2_pingpong_ram;

    localparam int AW = 6;
    localparam int DW = 36;
    localparam int N  = 1 << AW;

    logic          clk_sys = 1'b0;
    logic          rst_sys = 1'b1;
    logic          wr_en   = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          wr_rdy;
    logic          wr_ovf;
    logic          rd_req  = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_last = 1'b0;
    logic          rd_rdy;
    logic [DW-1:0] rd_data;
    logic          rd_vld;

    always #5 clk_sys = ~clk_sys;

    r4u2_pingpong_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_last (wr_last),
        .wr_rdy  (wr_rdy),
        .wr_ovf  (wr_ovf),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_last (rd_last),
        .rd_rdy  (rd_rdy),
        .rd_data (rd_data),
        .rd_vld  (rd_vld)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_mem [2][N];
    logic          m_full [2];
    logic          m_wb;
    logic          m_rb;
    logic          e_ovf;
    logic [DW-1:0] last_data;
    logic [DW-1:0] sb_q [$];
    bit            mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus; model advances with the same acceptance rules.
    task automatic cycle(input bit w, input int wa, input logic [DW-1:0] wd, input bit wl,
                         input bit r, input int ra, input bit rl);
        bit wacc;
        bit racc;
        @(negedge clk_sys);
        rst_sys = 1'b0;
        wr_en   = ~w;
        wr_addr = wa[AW-1:0];
        wr_data = wd;
        wr_last = wl;
        rd_req  = r;
        rd_addr = ra[AW-1:0];
        rd_last = rl;
        wacc  = w && !m_full[m_wb];
        racc  = r && m_full[m_rb];
        e_ovf = w && m_full[m_wb];
        if (racc) sb_q.push_back(m_mem[m_rb][ra[AW-1:0]]);
        if (wacc) m_mem[m_wb][wa[AW-1:0]] = wd;
        if (wacc && wl) begin
            m_full[m_wb] = 1'b1;
            m_wb = ~m_wb;
        end
        if (racc && rl) begin
            m_full[m_rb] = 1'b0;
            m_rb = ~m_rb;
        end
        @(posedge clk_sys);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_sys);
        rst_sys = 1'b1;
        wr_en   = 1'b0;
        wr_last = 1'b1;
        rd_req  = 1'b1;
        rd_last = 1'b1;
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wb      = 1'b0;
        m_rb      = 1'b0;
        e_ovf     = 1'b0;
        last_data = '0;
        sb_q.delete();
        mon_en    = 1'b1;
        for (int i = 0; i < n; i++) @(posedge clk_sys);
    endtask

    always @(posedge clk_sys) begin
        #1;
        if (mon_en) begin
            check_eq("wr_rdy", {63'b0, wr_rdy}, {63'b0, !m_full[m_wb]});
            check_eq("rd_rdy", {63'b0, rd_rdy}, {63'b0, m_full[m_rb]});
            check_eq("wr_ovf", {63'b0, wr_ovf}, {63'b0, e_ovf});
            check_eq("rd_vld", {63'b0, rd_vld}, {63'b0, sb_q.size() != 0});
            if (sb_q.size() != 0) begin
                last_data = sb_q.pop_front();
                check_eq("rd_data", {28'b0, rd_data}, {28'b0, last_data});
            end else begin
                check_eq("rd_hold", {28'b0, rd_data}, {28'b0, last_data});
            end
        end
    end

    initial begin
        // 1: reset values (write/read strobes active during reset must be ignored)
        do_reset(2);
        idle(1);

        // 2: sequential fill, reverse-order readback
        for (int i = 0; i < N; i++) cycle(1, i, DW'(32'h100 + i), i == N-1, 0, 0, 0);
        for (int i = N-1; i >= 0; i--) cycle(0, 0, '0, 0, 1, i, i == 0);
        idle(2);

        // 3: fill A, write B while reading A, straight into reading B
        for (int i = 0; i < N; i++) cycle(1, N-1-i, DW'(32'h300 + i), i == N-1, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(1, i, DW'(32'h200 + i), i == N-1, 1, i, i == N-1);
        for (int i = 0; i < N; i++) cycle(0, 0, '0, 0, 1, i, i == N-1);
        idle(2);

        // 4: two frames without reading, then dropped writes
        for (int i = 0; i < N; i++) cycle(1, i, DW'(32'h400 + i), i == N-1, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(1, i, DW'(32'h500 + i), i == N-1, 0, 0, 0);
        cycle(1, 5, DW'(32'hDEAD), 0, 0, 0, 0);
        idle(1);
        cycle(1, 5, DW'(32'hBEEF), 1, 0, 0, 0);
        cycle(1, 6, DW'(32'hBEEF), 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 2*N; i++) cycle(0, 0, '0, 0, 1, (i % N) ^ 6'h2A, (i % N) == N-1);
        idle(2);

        // 5: random addresses, aligned write-last / read-last swap
        for (int i = 0; i < N; i++) cycle(1, i, DW'($urandom), i == N-1, 0, 0, 0);
        for (int i = 0; i < N; i++)
            cycle(1, (i == N-1) ? 0 : $urandom_range(N-1), DW'($urandom), i == N-1,
                  1, $urandom_range(N-1), i == N-1);
        for (int i = 0; i < N; i++) cycle(0, 0, '0, 0, 1, i, i == N-1);
        idle(2);

        // 6: reset mid-frame on both sides, then a fresh frame
        for (int i = 0; i < N; i++) cycle(1, i, DW'(32'h600 + i), i == N-1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, i, DW'(32'h650 + i), 0, 1, i, 0);
        do_reset(1);
        idle(2);
        cycle(0, 0, '0, 0, 1, 3, 1);
        for (int i = 0; i < N; i++) cycle(1, i, DW'(32'h700 + i), i == N-1, 0, 0, 0);
        for (int i = 0; i < N; i++) cycle(0, 0, '0, 0, 1, N-1-i, i == N-1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
